// File: rtl/ir_frame_decoder.sv
// ir_frame_decoder: IR serial frame receiver for a button pad.
// Frame format: low start cell, DATA_W data bits (MSB first),
// optional even-parity cell, high stop cell.
// Each cell is BIT_TICKS clocks long.
// Optional feature macro: IR_PARITY_EN.
//   When defined, one even-parity cell follows the data bits.
// Accepted codes appear on buttons, with rdy held high for RDY_CYCLES.
// Rejected frames give a one-cycle err pulse and leave buttons unchanged.
// rnd free-runs while idle and serves as a seed for game colours.
module ir_frame_decoder #(
  parameter int                       DATA_W     = 3,
  parameter int                       BIT_TICKS  = 12,
  parameter logic [(2**DATA_W)-1:0]   VALID_MASK = 8'h5E,
  parameter int                       RDY_CYCLES = 4,
  parameter int                       RND_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              irda,
  output logic [DATA_W-1:0] buttons,
  output logic              rdy,
  output logic              err,
  output logic [RND_W-1:0]  rnd
);

  localparam int BIT_IDX_W = $clog2(DATA_W + 1);

  localparam logic [7:0]           HALF_LAST = 8'(BIT_TICKS / 2 - 1);
  localparam logic [7:0]           CELL_LAST = 8'(BIT_TICKS - 1);
  localparam logic [7:0]           OUT_LAST  = 8'(RDY_CYCLES - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_LAST  = BIT_IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef IR_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  state_t               state_r;
  logic [7:0]           tick_r;
  logic [BIT_IDX_W-1:0] bit_idx_r;
  logic [DATA_W-1:0]    shift_r;
  logic                 par_r;
  logic                 accept_s;

  // Even parity holds when the XOR of the data and parity bits is zero.
  function automatic logic parity_ok(input logic [DATA_W-1:0] d, input logic p);
    return ~((^d) ^ p);
  endfunction

  // Frame acceptance at the stop sample: stop high, code allowed, parity good.
  always_comb begin
    accept_s = irda & VALID_MASK[shift_r];
`ifdef IR_PARITY_EN
    accept_s = accept_s & parity_ok(shift_r, par_r);
`else
    accept_s = accept_s & 1'b1;
`endif
  end

  // Receiver FSM with registered outputs and idle-time seed counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      tick_r    <= 8'd0;
      bit_idx_r <= '0;
      shift_r   <= '0;
      par_r     <= 1'b0;
      buttons   <= '0;
      rdy       <= 1'b0;
      err       <= 1'b0;
      rnd       <= '0;
    end else begin
      err <= 1'b0;
      case (state_r)
        S_IDLE: begin
          rnd <= rnd + RND_W'(1);
          if (!irda) begin
            tick_r  <= 8'd0;
            state_r <= S_START;
          end
        end
        S_START: begin
          if (tick_r == HALF_LAST) begin
            if (irda) begin
              // Start cell too short: treat as a glitch, no error.
              state_r <= S_IDLE;
            end else begin
              tick_r    <= 8'd0;
              bit_idx_r <= '0;
              state_r   <= S_DATA;
            end
          end else begin
            tick_r <= tick_r + 8'd1;
          end
        end
        S_DATA: begin
          if (tick_r == CELL_LAST) begin
            shift_r <= (shift_r << 1) | DATA_W'(irda);
            tick_r  <= 8'd0;
            if (bit_idx_r == BIT_LAST) begin
`ifdef IR_PARITY_EN
              state_r <= S_PARITY;
`else
              state_r <= S_STOP;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + BIT_IDX_W'(1);
            end
          end else begin
            tick_r <= tick_r + 8'd1;
          end
        end
`ifdef IR_PARITY_EN
        S_PARITY: begin
          if (tick_r == CELL_LAST) begin
            par_r   <= irda;
            tick_r  <= 8'd0;
            state_r <= S_STOP;
          end else begin
            tick_r <= tick_r + 8'd1;
          end
        end
`endif
        S_STOP: begin
          if (tick_r == CELL_LAST) begin
            tick_r <= 8'd0;
            if (accept_s) begin
              buttons <= shift_r;
              rdy     <= 1'b1;
              state_r <= S_OUT;
            end else begin
              err     <= 1'b1;
              state_r <= S_IDLE;
            end
          end else begin
            tick_r <= tick_r + 8'd1;
          end
        end
        S_OUT: begin
          // The line is ignored while the code is being presented.
          if (tick_r == OUT_LAST) begin
            rdy     <= 1'b0;
            tick_r  <= 8'd0;
            state_r <= S_IDLE;
          end else begin
            tick_r <= tick_r + 8'd1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          tick_r  <= 8'd0;
          rdy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_frame_decoder.sv
// Self-checking bench for ir_frame_decoder (default parameters).
// Frames are driven cell by cell.
// Expected rdy/err/buttons/rnd values come from a frame-level model.
module tb_ir_frame_decoder;

  localparam int BT = 12;
  localparam int R  = 4;

  logic       clk;
  logic       rst;
  logic       irda;
  logic [2:0] buttons;
  logic       rdy;
  logic       err;
  logic [1:0] rnd;

  int total = 0;
  int bad   = 0;
  logic [2:0] model_btn = 3'd0;
  int valid_codes[5] = '{1, 2, 3, 4, 6};

  ir_frame_decoder dut (
    .clk(clk), .rst(rst), .irda(irda),
    .buttons(buttons), .rdy(rdy), .err(err), .rnd(rnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_valid(input logic [2:0] code);
    foreach (valid_codes[k]) if (valid_codes[k] == int'(code)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int n_cells();
`ifdef IR_PARITY_EN
    return 6;
`else
    return 5;
`endif
  endfunction

  // Sample index (negedges after the start edge) at which the result first shows.
  function automatic int first_idx();
    return BT / 2 + BT * (n_cells() - 1) + 1;
  endfunction

  // Line high; after settling, rnd must count up by one each idle cycle.
  task automatic idle_gap(input int n);
    logic [1:0] prev;
    logic [1:0] nx;
    irda = 1'b1;
    repeat (3) @(negedge clk);
    prev = rnd;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      nx = prev + 2'd1;
      chk("rnd_idle_count", rnd, nx);
      chk("idle_rdy", rdy, 1'b0);
      chk("idle_err", err, 1'b0);
      prev = rnd;
    end
  endtask

  // Drive one frame; abort_at >= 0 pulses rst at that sample index.
  task automatic run_frame(input logic [2:0] code, input logic stop_b,
                           input logic par_b, input int abort_at);
    logic lv[$];
    int   nc, tlen, first;
    bit   acc;
    logic [2:0] old_btn, exp_btn;
    logic [1:0] r_hold;
    logic exp_rdy, exp_err;
    lv = {};
    lv.push_back(1'b0);
    lv.push_back(code[2]);
    lv.push_back(code[1]);
    lv.push_back(code[0]);
`ifdef IR_PARITY_EN
    lv.push_back(par_b);
`endif
    lv.push_back(stop_b);
    nc    = lv.size();
    tlen  = nc * BT;
    first = first_idx();
    acc   = stop_b && is_valid(code);
`ifdef IR_PARITY_EN
    acc   = acc && ((code[0] ^ code[1] ^ code[2] ^ par_b) == 1'b0);
`else
    acc   = acc && (par_b == par_b);
`endif
    old_btn = model_btn;
    r_hold  = 2'd0;
    for (int i = 0; i <= tlen + 1; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_rdy = acc && (i >= first) && (i < first + R);
        exp_err = !acc && (i == first);
        exp_btn = (acc && i >= first) ? code : old_btn;
        chk("frame_rdy", rdy, exp_rdy);
        chk("frame_err", err, exp_err);
        chk("rdy_err_excl", rdy & err, 1'b0);
        chk("frame_buttons", buttons, exp_btn);
        if (i == 1) r_hold = rnd;
        else if (i <= first) chk("rnd_hold", rnd, r_hold);
      end
      if (i == abort_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_buttons", buttons, 3'd0);
        chk("rst_rdy", rdy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rnd", rnd, 2'd0);
        @(negedge clk);
        irda = 1'b1;
        rst  = 1'b0;
        model_btn = 3'd0;
        return;
      end
      irda = (i / BT < nc) ? lv[i / BT] : 1'b1;
    end
    if (acc) model_btn = code;
  endtask

  initial begin
    logic [2:0] c;
    logic       s, p;
    rst  = 1'b1;
    irda = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_buttons", buttons, 3'd0);
    chk("reset_rdy", rdy, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_rnd", rnd, 2'd0);
    rst = 1'b0;
    idle_gap(5);

    // Good frame 110, then a disallowed code 000 (buttons keep 110).
    run_frame(3'b110, 1'b1, 1'b0, -1);
    chk("btn_after_110", buttons, 3'b110);
    idle_gap(3);
    run_frame(3'b000, 1'b1, 1'b0, -1);
    chk("btn_after_000", buttons, 3'b110);
    idle_gap(3);

    // Start glitch: low for 3 cycles only.
    irda = 1'b0;
    repeat (3) @(negedge clk);
    irda = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("glitch_rdy", rdy, 1'b0);
      chk("glitch_err", err, 1'b0);
    end
    idle_gap(4);
    chk("btn_after_glitch", buttons, 3'b110);

    // Allowed code with a low stop cell is a framing error.
    run_frame(3'b001, 1'b0, 1'b1, -1);
    chk("btn_after_badstop", buttons, 3'b110);
    idle_gap(3);

`ifdef IR_PARITY_EN
    run_frame(3'b011, 1'b1, 1'b0, -1);
    chk("btn_par_good", buttons, 3'b011);
    idle_gap(3);
    run_frame(3'b011, 1'b1, 1'b1, -1);
    chk("btn_par_bad", buttons, 3'b011);
    idle_gap(3);
`endif

    // Reset mid-data, then a full frame; reset during OUT, then a full frame.
    run_frame(3'b010, 1'b1, 1'b1, 2 * BT + 3);
    idle_gap(3);
    run_frame(3'b010, 1'b1, 1'b1, -1);
    chk("btn_after_rst_data", buttons, 3'b010);
    idle_gap(3);
    run_frame(3'b100, 1'b1, 1'b1, first_idx() + 1);
    idle_gap(3);
    run_frame(3'b010, 1'b1, 1'b1, -1);
    chk("btn_after_rst_out", buttons, 3'b010);
    idle_gap(3);

    // Randomized frames.
    for (int n = 0; n < 30; n++) begin
      c = 3'($urandom_range(0, 7));
      s = ($urandom_range(0, 4) != 0);
      p = (c[0] ^ c[1] ^ c[2]) ^ ($urandom_range(0, 3) == 0);
      run_frame(c, s, p, -1);
      chk("rand_buttons", buttons, model_btn);
      idle_gap($urandom_range(1, 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_frame_decoder.md
IR_FRAME_DECODER -- requirements
Module: ir_frame_decoder

Interface
REQ-001 Parameter DATA_W, default 3: number of data bits per frame.
REQ-002 Parameter BIT_TICKS, default 12: clk cycles per bit cell (start, data, parity, stop); allowed range 4..255.
REQ-003 Parameter VALID_MASK, width 2**DATA_W, default 8'h5E: bit k set means code k is accepted (default accepts 1, 2, 3, 4, 6).
REQ-004 Parameter RDY_CYCLES, default 4: rdy pulse length in clk cycles; allowed range 1..255.
REQ-005 Parameter RND_W, default 2: width of the free-running seed output.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 irda  in  1  serial IR line; idles high; frame starts with a low start cell.
REQ-009 buttons  out  DATA_W  last accepted code, MSB received first.
REQ-010 rdy  out  1  high while a newly accepted code is presented.
REQ-011 err  out  1  one-cycle pulse for a rejected frame.
REQ-012 rnd  out  RND_W  free-running seed counter (game colour seed).

Function
REQ-013 FSM states: IDLE, START, DATA, PARITY (only when compiled in), STOP, OUT.
REQ-014 IDLE: rnd increments by 1 each cycle, wrapping modulo 2**RND_W; rnd holds in every other state.
REQ-015 IDLE with irda==0 sampled: clear tick counter, go to START.
REQ-016 START: at tick BIT_TICKS/2-1 (integer division), irda==1 means glitch: return to IDLE, no err; irda==0: clear tick counter and bit index, go to DATA.
REQ-017 DATA: sample irda when tick counter reaches BIT_TICKS-1 (mid-cell), shift into the shift register MSB first, clear counter; after DATA_W samples, go to PARITY if compiled in, else STOP.
REQ-018 STOP: sample at mid-cell; irda==0 is a framing error.
REQ-019 Accept when stop==1, VALID_MASK[code]==1, and parity is OK when compiled in; otherwise reject.
REQ-020 Accept: on the cycle after the stop sample, load buttons with the code and go to OUT; rdy high exactly RDY_CYCLES cycles, then IDLE.
REQ-021 Reject: on the cycle after the stop sample, err high for one cycle, buttons unchanged, go to IDLE.
REQ-022 buttons holds its value between accepted frames; never shows partial data.
REQ-023 irda is ignored in OUT; a line still low on re-entry to IDLE starts a new frame.
REQ-024 Tick counter is at least 8 bits; bit index is sized for DATA_W+1 with no overflow.
REQ-025 rdy and err are never high in the same cycle.

Reset
REQ-026 rst==1 asynchronously forces IDLE and clears the tick counter, bit index, shift register, buttons, rdy, err and rnd to 0, including mid-frame or during OUT.
REQ-027 The first frame after rst deasserts requires a fresh irda==0 sample in IDLE.

Configuration
REQ-028 Macro IR_PARITY_EN defined: one even-parity cell follows the data bits; a frame is accepted only if XOR(data bits, parity bit)==0.
REQ-029 Macro IR_PARITY_EN undefined: no PARITY state; the stop cell directly follows the last data bit.

Verification (defaults, BIT_TICKS=12, parity off unless noted)
REQ-030 Start low 12 cycles, data 1,1,0 at 12 cycles each, stop high -> buttons=3'b110, rdy high 4 cycles starting the cycle after the stop sample, err=0.
REQ-031 Same framing with data 0,0,0 -> err high 1 cycle, rdy=0, buttons keeps its prior value (3'b110).
REQ-032 irda low 3 cycles, then high -> no frame decoded, err=0, rdy=0, FSM back in IDLE, rnd resumes counting.
REQ-033 Valid data 0,0,1 with stop cell low -> err pulse, buttons unchanged.
REQ-034 IR_PARITY_EN defined: data 0,1,1 with parity 0 -> buttons=3'b011 and rdy; same data with parity 1 -> err pulse.
REQ-035 rst pulsed mid-DATA and separately during OUT -> all outputs 0 immediately; next full 3'b010 frame -> buttons=3'b010 and rdy.
